// File: rtl/gmii_tx_mac_if.sv
// Byte-stream handshake between a frame source and the GMII transmit framer.
// The source drives data/valid/last and the framer answers with ready.
interface gmii_tx_mac_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );
endinterface

// File: rtl/gmii_tx_mac.sv
// Transmit MAC framer: wraps a payload byte stream with preamble, SFD,
// zero padding and the Ethernet FCS, then holds off for the inter-frame gap.
// Every GMII output is registered; the byte registered in a cycle belongs to
// the state the FSM is in during that cycle, so the transition out of IDLE
// already launches the first preamble byte.
module gmii_tx_mac #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic           gmii_tx_clk,
  input  logic           sys_rst_n,
  gmii_tx_mac_if.slave   s_axis,
  output logic [7:0]     gmii_txd,
  output logic           gmii_tx_en,
  output logic           gmii_tx_er,
  output logic           tx_busy,
  output logic           frame_done,
  output logic           underrun
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_FCS  = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;
  localparam logic [2:0] ST_DROP = 3'd7;

  // The IDLE exit already emits one preamble byte, so PRE covers the rest.
  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 2);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);

  logic [2:0]  state;
  logic [10:0] cnt;
  logic [31:0] crc;
  logic [11:0] cnt_inc;
  logic [10:0] cnt_sat;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0x04C11DB7 as 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The pad compare uses an unsaturated 12-bit view so long frames never pad.
  assign cnt_inc = {1'b0, cnt} + 12'd1;
  assign cnt_sat = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
  assign fcs     = ~crc;

  // DROP also accepts bytes so an aborted frame can be drained upstream.
  assign s_axis.s_tready = (state == ST_DATA) || (state == ST_DROP);
  assign tx_busy         = (state != ST_IDLE);

  // Select the FCS byte to send, least significant byte first.
  always_comb begin
    fcs_byte = fcs[7:0];
    case (cnt[1:0])
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      2'd3:    fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  // Framing FSM with registered GMII outputs, CRC and the shared byte counter.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 11'd0;
      crc        <= 32'hFFFFFFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_axis.s_tvalid) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
            cnt        <= 11'd0;
            state      <= (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
          end
        end
        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'h55;
          if (cnt == PRE_LAST) state <= ST_SFD;
          else                 cnt   <= cnt + 11'd1;
        end
        ST_SFD: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= 8'hD5;
          crc        <= 32'hFFFFFFFF;
          cnt        <= 11'd0;
          state      <= ST_DATA;
        end
        ST_DATA: begin
          gmii_tx_en <= 1'b1;
          if (s_axis.s_tvalid) begin
            gmii_txd <= s_axis.s_tdata;
            crc      <= crc32_byte(crc, s_axis.s_tdata);
            cnt      <= cnt_sat;
            if (s_axis.s_tlast) begin
              if (cnt_inc < MIN_LEN) begin
                state <= ST_PAD;
              end else begin
                state <= ST_FCS;
                cnt   <= 11'd0;
              end
            end
          end else begin
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            cnt        <= 11'd0;
            state      <= s_axis.s_tlast ? ST_IFG : ST_DROP;
          end
        end
        ST_PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc32_byte(crc, 8'h00);
          cnt        <= cnt_sat;
          if (cnt_inc >= MIN_LEN) begin
            state <= ST_FCS;
            cnt   <= 11'd0;
          end
        end
        ST_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= fcs_byte;
          if (cnt[1:0] == 2'd3) begin
            frame_done <= 1'b1;
            cnt        <= 11'd0;
            state      <= ST_IFG;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        ST_IFG: begin
          if (cnt == IFG_LAST) begin
            cnt   <= 11'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        ST_DROP: begin
          if (s_axis.s_tvalid && s_axis.s_tlast) begin
            cnt   <= 11'd0;
            state <= ST_IFG;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: one default instance and one with padding
// disabled; a negedge monitor collects every tx_en byte for comparison.
module tb_gmii_tx_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_tx_mac_if if_d ();
  gmii_tx_mac_if if_z ();

  logic [7:0] d_txd, z_txd;
  logic d_en, d_er, d_busy, d_done, d_unr;
  logic z_en, z_er, z_busy, z_done, z_unr;

  gmii_tx_mac dut (
    .gmii_tx_clk(clk), .sys_rst_n(rst_n), .s_axis(if_d),
    .gmii_txd(d_txd), .gmii_tx_en(d_en), .gmii_tx_er(d_er),
    .tx_busy(d_busy), .frame_done(d_done), .underrun(d_unr)
  );

  gmii_tx_mac #(.MIN_FRAME(0)) dut_nopad (
    .gmii_tx_clk(clk), .sys_rst_n(rst_n), .s_axis(if_z),
    .gmii_txd(z_txd), .gmii_tx_en(z_en), .gmii_tx_er(z_er),
    .tx_busy(z_busy), .frame_done(z_done), .underrun(z_unr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q_d[$];
  logic [7:0] q_z[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay [0:127];

  int en_cyc_d = 0, gap_d = 0, last_gap_d = 0, done_d = 0, done_at_d = 0;
  int er_d = 0, er_at_d = 0, unr_d = 0, rdy_idle_d = 0;
  int done_z = 0, done_at_z = 0;

  // Capture the GMII stream and event counters of both instances on the falling edge.
  always @(negedge clk) begin
    if (d_done) begin done_d <= done_d + 1; done_at_d <= q_d.size() + 1; end
    if (d_er) begin er_d <= er_d + 1; er_at_d <= q_d.size() + 1; end
    if (d_unr) unr_d <= unr_d + 1;
    if (if_d.s_tready && !d_en) rdy_idle_d <= rdy_idle_d + 1;
    if (d_en) begin
      q_d.push_back(d_txd);
      en_cyc_d <= en_cyc_d + 1;
      if (gap_d != 0) last_gap_d <= gap_d;
      gap_d <= 0;
    end else begin
      gap_d <= gap_d + 1;
    end
    if (z_done) begin done_z <= done_z + 1; done_at_z <= q_z.size() + 1; end
    if (z_en) q_z.push_back(z_txd);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if ((r[0] ^ d[b]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Expected frame: preamble, SFD, payload, zero pad, FCS from the model.
  task automatic buildExpected(input int n, input int min_frame);
    logic [31:0] c;
    int total;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pay[k]);
      c = crcByte(c, pay[k]);
    end
    total = n;
    while (total < min_frame) begin
      exp_q.push_back(8'h00);
      c = crcByte(c, 8'h00);
      total++;
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic compareFrame(input int sel, input int start, input string tag);
    int n;
    n = (sel != 0) ? q_z.size() - start : q_d.size() - start;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < n) checkOutput($sformatf("%s_byte%0d", tag, k),
                             (sel != 0) ? q_z[start + k] : q_d[start + k], exp_q[k]);
      else       checkOutput($sformatf("%s_missing%0d", tag, k), 32'hDEAD, exp_q[k]);
    end
  endtask

  task automatic driveByte(input int sel, input logic [7:0] d, input logic last, input logic vld);
    if (sel != 0) begin if_z.s_tdata = d; if_z.s_tlast = last; if_z.s_tvalid = vld; end
    else          begin if_d.s_tdata = d; if_d.s_tlast = last; if_d.s_tvalid = vld; end
  endtask

  // Send pay[0..len-1]; optionally drop valid for one cycle once stall_at bytes are accepted.
  task automatic applyStimulus(input int sel, input int len, input int stall_at, output int sent);
    int i, guard;
    logic acc, stalled;
    i = 0; guard = 0; stalled = 1'b0;
    driveByte(sel, pay[0], len == 1, 1'b1);
    while (i < len) begin
      acc = (sel != 0) ? (if_z.s_tready && if_z.s_tvalid) : (if_d.s_tready && if_d.s_tvalid);
      @(negedge clk);
      if (acc) i++;
      if (i == stall_at && !stalled) begin
        driveByte(sel, 8'h00, 1'b0, 1'b0);
        stalled = 1'b1;
      end else if (i < len) begin
        driveByte(sel, pay[i], i == len - 1, 1'b1);
      end else begin
        driveByte(sel, 8'h00, 1'b0, 1'b0);
      end
      guard++;
      if (guard > 4000) begin
        checkOutput("send_timeout", i, len);
        break;
      end
    end
    sent = i;
  endtask

  task automatic waitIdle(input int sel, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (((sel != 0) ? z_busy : d_busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, (sel != 0) ? z_busy : d_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, e0, dn0, er0, un0, r0, sent, n;
    driveByte(0, 8'h00, 1'b0, 1'b0);
    driveByte(1, 8'h00, 1'b0, 1'b0);

    // Reset state
    #20;
    checkOutput("rst_tx_en", d_en, 1'b0);
    checkOutput("rst_txd", d_txd, 8'h00);
    checkOutput("rst_tx_er", d_er, 1'b0);
    checkOutput("rst_busy", d_busy, 1'b0);
    checkOutput("rst_tready", if_d.s_tready, 1'b0);
    checkOutput("rst_done", d_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: "123456789" with padding disabled, hand-computed FCS
    $display("[TB] test 1: check string, no padding");
    for (int k = 0; k < 9; k++) pay[k] = 8'h31 + 8'(k);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h31 + 8'(k));
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    s0 = q_z.size(); dn0 = done_z;
    applyStimulus(1, 9, -1, sent);
    waitIdle(1, "t1_idle");
    checkOutput("t1_len", q_z.size() - s0, 21);
    compareFrame(1, s0, "t1");
    checkOutput("t1_done_cnt", done_z - dn0, 1);
    checkOutput("t1_done_pos", done_at_z - s0, 21);

    // Test 2: 14-byte frame padded to 60, tx_en for 72 cycles
    $display("[TB] test 2: 14-byte frame with pad");
    for (int k = 0; k < 14; k++) pay[k] = 8'h10 + 8'(k * 7);
    buildExpected(14, 60);
    s0 = q_d.size(); e0 = en_cyc_d; dn0 = done_d;
    checkOutput("t2_en_before", d_en, 1'b0);
    driveByte(0, pay[0], 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t2_latency_en", d_en, 1'b1);
    checkOutput("t2_latency_txd", d_txd, 8'h55);
    applyStimulus(0, 14, -1, sent);
    waitIdle(0, "t2_idle");
    checkOutput("t2_en_cycles", en_cyc_d - e0, 72);
    compareFrame(0, s0, "t2");
    checkOutput("t2_done_pos", done_at_d - s0, 72);
    checkOutput("t2_done_cnt", done_d - dn0, 1);

    // Test 3: two 64-byte frames back to back, exactly 12 idle cycles between
    $display("[TB] test 3: back-to-back frames");
    for (int k = 0; k < 64; k++) pay[k] = 8'(k) ^ 8'h5A;
    buildExpected(64, 60);
    s0 = q_d.size(); e0 = en_cyc_d; dn0 = done_d; r0 = rdy_idle_d;
    applyStimulus(0, 64, -1, sent);
    applyStimulus(0, 64, -1, sent);
    waitIdle(0, "t3_idle");
    checkOutput("t3_en_cycles", en_cyc_d - e0, 152);
    checkOutput("t3_gap", last_gap_d, 12);
    checkOutput("t3_ready_in_gap", rdy_idle_d - r0, 0);
    checkOutput("t3_done_cnt", done_d - dn0, 2);
    compareFrame(0, s0, "t3a");
    compareFrame(0, s0 + 76, "t3b");

    // Test 4: underrun after 20 bytes of a 100-byte frame
    $display("[TB] test 4: underrun and drain");
    for (int k = 0; k < 100; k++) pay[k] = 8'hC0 ^ 8'(k);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 20; k++) exp_q.push_back(pay[k]);
    exp_q.push_back(8'h00);
    s0 = q_d.size(); dn0 = done_d; er0 = er_d; un0 = unr_d;
    applyStimulus(0, 100, 20, sent);
    checkOutput("t4_drained", sent, 100);
    waitIdle(0, "t4_idle");
    checkOutput("t4_len", q_d.size() - s0, 29);
    compareFrame(0, s0, "t4");
    checkOutput("t4_er_cnt", er_d - er0, 1);
    checkOutput("t4_er_pos", er_at_d - s0, 29);
    checkOutput("t4_underrun_cnt", unr_d - un0, 1);
    checkOutput("t4_no_done", done_d - dn0, 0);

    // Test 5: reset during FCS, then a clean frame
    $display("[TB] test 5: reset during FCS");
    for (int k = 0; k < 60; k++) pay[k] = 8'(k * 3 + 1);
    s0 = q_d.size(); dn0 = done_d;
    applyStimulus(0, 60, -1, sent);
    n = 0;
    while (q_d.size() < s0 + 69 && n < 200) begin @(negedge clk); n++; end
    checkOutput("t5_reached_fcs", d_en, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_en", d_en, 1'b0);
    checkOutput("t5_rst_txd", d_txd, 8'h00);
    checkOutput("t5_rst_er", d_er, 1'b0);
    checkOutput("t5_rst_busy", d_busy, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t5_aborted_no_done", done_d - dn0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 14; k++) pay[k] = 8'hE1 - 8'(k * 5);
    buildExpected(14, 60);
    s0 = q_d.size(); dn0 = done_d;
    applyStimulus(0, 14, -1, sent);
    waitIdle(0, "t5_idle");
    checkOutput("t5_len", q_d.size() - s0, 72);
    compareFrame(0, s0, "t5");
    checkOutput("t5_done_cnt", done_d - dn0, 1);

    // Test 6: single-byte frame padded with 59 zeros
    $display("[TB] test 6: single-byte frame");
    pay[0] = 8'hAB;
    buildExpected(1, 60);
    s0 = q_d.size(); dn0 = done_d;
    applyStimulus(0, 1, -1, sent);
    waitIdle(0, "t6_busy_low");
    checkOutput("t6_len", q_d.size() - s0, 72);
    compareFrame(0, s0, "t6");
    checkOutput("t6_done_cnt", done_d - dn0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the run stalls outside a bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
